sem_fifo_connector: RTL and testbench

- Parametrised successor to the single-entry, single-bit semaphore memory connector.
- Buffers WIDTH-bit words from producer A to consumer B in a DEPTH-entry first-word-fall-through FIFO.
- Adds a fill level, an almost-full flag, a sticky overflow flag and a synchronous flush.
- Sits between a semaphore producer and consumer. Producer keeps a write/data/space interface; consumer keeps a valid/data/ready handshake.

---
 rtl/sem_pkg.sv | 19 +
 rtl/sem_fifo_ptr.sv | 37 +++
 rtl/sem_fifo_connector.sv | 101 ++++++++++
 tb/tb_sem_fifo_connector.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sem_pkg.sv
// Shared helpers and defaults for the semaphore FIFO connector.
// Width functions keep the level and pointer sizing consistent between modules.
package sem_pkg;

    localparam int unsigned SEM_DEFAULT_WIDTH = 8;
    localparam int unsigned SEM_DEFAULT_DEPTH = 4;

    function automatic int unsigned sem_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry FIFO still needs a 1-bit pointer.
    function automatic int unsigned sem_pw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef logic [sem_cw(SEM_DEFAULT_DEPTH)-1:0] sem_level_t;

endpackage

// File: rtl/sem_fifo_ptr.sv
// Circular FIFO pointer: advances on inc, wraps from DEPTH-1 to 0, clr has priority.
module sem_fifo_ptr
    import sem_pkg::*;
#(
    parameter int unsigned DEPTH = SEM_DEFAULT_DEPTH
) (
    input  logic                     clk_s,
    input  logic                     rst_s,
    input  logic                     clr,
    input  logic                     inc,
    output logic [sem_pw(DEPTH)-1:0] ptr
);

    localparam int unsigned PW = sem_pw(DEPTH);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sem_fifo_connector.sv
// First-word-fall-through FIFO between a semaphore producer (A) and consumer (B),
// with fill level, almost-full, sticky overflow and synchronous flush.
module sem_fifo_connector
    import sem_pkg::*;
#(
    parameter int unsigned WIDTH       = SEM_DEFAULT_WIDTH,
    parameter int unsigned DEPTH       = SEM_DEFAULT_DEPTH,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
    input  logic                     clk_s,
    input  logic                     rst_s,
    input  logic                     sema_flush_i_s,
    input  logic                     sema_write_o_s_A,
    input  logic [WIDTH-1:0]         sema_data_o_s_A,
    output logic                     sema_is_empty_i_s_A,
    output logic                     sema_valid_i_s_B,
    output logic [WIDTH-1:0]         sema_data_i_s_B,
    input  logic                     sema_ready_o_s_B,
    output logic [sem_cw(DEPTH)-1:0] sema_level_o_s,
    output logic                     sema_afull_o_s,
    output logic                     sema_overflow_o_s
);

    localparam int unsigned CW = sem_cw(DEPTH);
    localparam int unsigned PW = sem_pw(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             full, not_empty, push, pop;

    // Space and valid come only from the registered count, so a same-cycle pop
    // never opens room for a write.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        not_empty = (count_q != '0);
        push      = sema_write_o_s_A && !full && !sema_flush_i_s;
        pop       = sema_ready_o_s_B && not_empty && !sema_flush_i_s;

        count_d = count_q;
        if (sema_flush_i_s) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        ovf_d = ovf_q;
        if (sema_flush_i_s) begin
            ovf_d = 1'b0;
        end else if (sema_write_o_s_A && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_s) begin
        if (push) begin
            mem_q[wr_ptr] <= sema_data_o_s_A;
        end
    end

    sem_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk_s (clk_s),
        .rst_s (rst_s),
        .clr   (sema_flush_i_s),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    sem_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk_s (clk_s),
        .rst_s (rst_s),
        .clr   (sema_flush_i_s),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    assign sema_is_empty_i_s_A = !full;
    assign sema_valid_i_s_B    = not_empty;
    assign sema_data_i_s_B     = not_empty ? mem_q[rd_ptr] : '0;
    assign sema_level_o_s      = count_q;
    assign sema_afull_o_s      = (count_q >= CW'(AFULL_LEVEL));
    assign sema_overflow_o_s   = ovf_q;

endmodule

// File: tb/tb_sem_fifo_connector.sv
// Directed bench: a WIDTH=8/DEPTH=4 instance and a WIDTH=1/DEPTH=3 instance on one clock.
module tb_sem_fifo_connector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, DEPTH=4, AFULL_LEVEL=3
    logic       rst_a, flush_a, wr_a, rdy_a;
    logic [7:0] din_a, dout_a;
    logic       space_a, valid_a, afull_a, ovf_a;
    logic [2:0] level_a;

    // Instance B: WIDTH=1, DEPTH=3, AFULL_LEVEL=2
    logic       rst_b, flush_b, wr_b, rdy_b;
    logic [0:0] din_b, dout_b;
    logic       space_b, valid_b, afull_b, ovf_b;
    logic [1:0] level_b;

    int tests_run = 0;
    int tests_failed = 0;

    sem_fifo_connector #(
        .WIDTH       (8),
        .DEPTH       (4),
        .AFULL_LEVEL (3)
    ) u_dut_a (
        .clk_s               (clk),
        .rst_s               (rst_a),
        .sema_flush_i_s      (flush_a),
        .sema_write_o_s_A    (wr_a),
        .sema_data_o_s_A     (din_a),
        .sema_is_empty_i_s_A (space_a),
        .sema_valid_i_s_B    (valid_a),
        .sema_data_i_s_B     (dout_a),
        .sema_ready_o_s_B    (rdy_a),
        .sema_level_o_s      (level_a),
        .sema_afull_o_s      (afull_a),
        .sema_overflow_o_s   (ovf_a)
    );

    sem_fifo_connector #(
        .WIDTH       (1),
        .DEPTH       (3),
        .AFULL_LEVEL (2)
    ) u_dut_b (
        .clk_s               (clk),
        .rst_s               (rst_b),
        .sema_flush_i_s      (flush_b),
        .sema_write_o_s_A    (wr_b),
        .sema_data_o_s_A     (din_b),
        .sema_is_empty_i_s_A (space_b),
        .sema_valid_i_s_B    (valid_b),
        .sema_data_i_s_B     (dout_b),
        .sema_ready_o_s_B    (rdy_b),
        .sema_level_o_s      (level_b),
        .sema_afull_o_s      (afull_b),
        .sema_overflow_o_s   (ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [2:0] lvl, input logic space,
                         input logic vld, input logic [7:0] dat, input logic af,
                         input logic ov);
        chk({tag, ".level"}, 32'(level_a), 32'(lvl));
        chk({tag, ".space"}, 32'(space_a), 32'(space));
        chk({tag, ".valid"}, 32'(valid_a), 32'(vld));
        chk({tag, ".data"},  32'(dout_a),  32'(dat));
        chk({tag, ".afull"}, 32'(afull_a), 32'(af));
        chk({tag, ".ovf"},   32'(ovf_a),   32'(ov));
    endtask

    task automatic chk_b(input string tag, input logic [1:0] lvl, input logic space,
                         input logic vld, input logic dat, input logic af, input logic ov);
        chk({tag, ".level"}, 32'(level_b), 32'(lvl));
        chk({tag, ".space"}, 32'(space_b), 32'(space));
        chk({tag, ".valid"}, 32'(valid_b), 32'(vld));
        chk({tag, ".data"},  32'(dout_b),  32'(dat));
        chk({tag, ".afull"}, 32'(afull_b), 32'(af));
        chk({tag, ".ovf"},   32'(ovf_b),   32'(ov));
    endtask

    logic       bits [7];
    logic       q_b [$];
    logic [7:0] exp_byte;

    initial begin
        bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rst_a = 1'b1; flush_a = 1'b0; wr_a = 1'b0; rdy_a = 1'b0; din_a = '0;
        rst_b = 1'b1; flush_b = 1'b0; wr_b = 1'b0; rdy_b = 1'b0; din_b = '0;
        #1;
        chk_a("a_reset_async", 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        chk_a("a_idle", 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_b("b_idle", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Fill A with ready low
        wr_a = 1'b1;
        din_a = 8'h11; tick(); chk_a("a_push1", 3'd1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        din_a = 8'h22; tick(); chk_a("a_push2", 3'd2, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        din_a = 8'h33; tick(); chk_a("a_push3", 3'd3, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
        din_a = 8'h44; tick(); chk_a("a_push4", 3'd4, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0);

        // Write while full is dropped and sets overflow
        din_a = 8'h55; tick(); chk_a("a_ovf", 3'd4, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1);
        wr_a = 1'b0;
        tick(); chk_a("a_ovf_hold", 3'd4, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1);

        // Full + pop + write in one cycle: write still rejected
        wr_a = 1'b1; din_a = 8'h66; rdy_a = 1'b1;
        tick(); chk_a("a_full_popwr", 3'd3, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        wr_a = 1'b0;
        chk("a_pop_22", 32'(dout_a), 32'h22); tick();
        chk("a_pop_33", 32'(dout_a), 32'h33); tick();
        chk("a_pop_44", 32'(dout_a), 32'h44); tick();
        chk_a("a_drained", 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // Ready with nothing valid is ignored
        tick(); chk_a("a_ready_empty", 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        rdy_a = 1'b0;

        // Level 2, then ten simultaneous push/pop cycles across the pointer wrap
        wr_a = 1'b1;
        din_a = 8'hA0; tick();
        din_a = 8'hA1; tick();
        chk_a("a_lvl2", 3'd2, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b1);
        rdy_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din_a = 8'hA2 + 8'(i);
            exp_byte = 8'hA0 + 8'(i);
            chk($sformatf("a_stream_head%0d", i), 32'(dout_a), 32'(exp_byte));
            tick();
            chk($sformatf("a_stream_lvl%0d", i), 32'(level_a), 32'd2);
        end
        chk("a_stream_end", 32'(dout_a), 32'hAA);

        // Level 3 with overflow set, then flush with a concurrent write
        rdy_a = 1'b0; din_a = 8'hCC; tick();
        chk_a("a_lvl3", 3'd3, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
        din_a = 8'hDD; flush_a = 1'b1; tick();
        chk_a("a_flush", 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        flush_a = 1'b0; wr_a = 1'b0; tick();
        chk_a("a_flush_hold", 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        wr_a = 1'b1; din_a = 8'h77; tick(); wr_a = 1'b0;
        chk_a("a_after_flush", 3'd1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);

        // B: DEPTH=3, fill, then interleave across the 2->0 wrap
        wr_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_b = bits[i]; q_b.push_back(bits[i]); tick();
        end
        chk_b("b_full", 2'd3, 1'b0, 1'b1, q_b[0], 1'b1, 1'b0);
        wr_b = 1'b0; rdy_b = 1'b1;
        chk("b_pop_first", 32'(dout_b), 32'(q_b[0])); void'(q_b.pop_front()); tick();
        chk("b_lvl_after_pop", 32'(level_b), 32'd2);
        wr_b = 1'b1;
        for (int i = 3; i < 7; i++) begin
            din_b = bits[i];
            chk($sformatf("b_inter%0d", i), 32'(dout_b), 32'(q_b[0]));
            void'(q_b.pop_front()); q_b.push_back(bits[i]);
            tick();
            chk($sformatf("b_inter_lvl%0d", i), 32'(level_b), 32'd2);
        end
        wr_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("b_tail%0d", i), 32'(dout_b), 32'(q_b[0]));
            void'(q_b.pop_front()); tick();
        end
        rdy_b = 1'b0;
        chk_b("b_drained", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mid-burst asynchronous reset
        wr_b = 1'b1; din_b = 1'b1; tick(); tick();
        chk_b("b_pre_rst", 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst_b = 1'b1;
        #1;
        chk_b("b_async_rst", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_b = 1'b0;
        tick();
        chk_b("b_first_push", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wr_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
